// File: rtl/fp_mul_norm_round.sv
// fp_mul_norm_round: normalise / round / pack stage of the binary32 multiplier.
// Two pipeline registers: stage 1 normalises the 48-bit significand product and
// captures guard/sticky; stage 2 rounds, detects overflow/underflow and packs.
//
// Handshake: a beat moves on a rising edge when valid and ready are both high.
// advance = ~out_valid | out_ready stalls the whole pipe globally. in_ready is
// advance, so it does not depend on in_valid. While out_valid is high and
// out_ready is low, the output registers hold.
module fp_mul_norm_round #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_prod,
  input  logic [1:0]  in_cls,
  input  logic [1:0]  in_rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_inexact,
  output logic        out_inf,
  output logic        out_nan
);

  localparam logic [1:0] CLS_NORMAL = 2'b00;
  localparam logic [1:0] CLS_ZERO   = 2'b01;
  localparam logic [1:0] CLS_INF    = 2'b10;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Stage 1 registers
  logic               s1_valid;
  logic               s1_sign;
  logic signed [10:0] s1_exp;
  logic [23:0]        s1_mant;
  logic               s1_g;
  logic               s1_s;
  logic [1:0]         s1_cls;
  logic [1:0]         s1_rm;

  logic signed [10:0] exp_ext;
  assign exp_ext = $signed({in_exp[9], in_exp});

  // Stage 1: pick the leading one (bit 47 or 46) and capture guard/sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
      s1_cls   <= 2'b00;
      s1_rm    <= 2'b00;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_sign  <= in_sign;
      s1_cls   <= in_cls;
      s1_rm    <= in_rm;
      if (in_prod[47]) begin
        s1_mant <= in_prod[47:24];
        s1_g    <= in_prod[23];
        s1_s    <= |in_prod[22:0];
        s1_exp  <= exp_ext + 11'sd1;
      end else begin
        s1_mant <= in_prod[46:23];
        s1_g    <= in_prod[22];
        s1_s    <= |in_prod[21:0];
        s1_exp  <= exp_ext;
      end
    end
  end

  // Stage 2 combinational: round, range check, pack.
  logic               inc;
  logic [24:0]        mant_sum;
  logic [23:0]        mant_r;
  logic signed [10:0] exp_r;
  logic [31:0]        res_d;
  logic               ovf_d, unf_d, inx_d, inf_d, nan_d;

  // Rounding increment, post-round exponent/mantissa, then result selection.
  always_comb begin
    inc    = 1'b0;
    res_d  = 32'h0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    inx_d  = 1'b0;
    inf_d  = 1'b0;
    nan_d  = 1'b0;
    case (s1_rm)
      RM_RNE:  inc = s1_g & (s1_s | s1_mant[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = (s1_g | s1_s) & ~s1_sign;
      default: inc = (s1_g | s1_s) & s1_sign;
    endcase
    mant_sum = {1'b0, s1_mant} + {24'b0, inc};
    if (mant_sum[24]) begin
      mant_r = 24'h800000;
      exp_r  = s1_exp + 11'sd1;
    end else begin
      mant_r = mant_sum[23:0];
      exp_r  = s1_exp;
    end

    if (s1_cls == CLS_NORMAL) begin
      if (exp_r >= 11'sd255) begin
        ovf_d = 1'b1;
        inx_d = 1'b1;
        // Direction of rounding decides between infinity and largest finite.
        if ((s1_rm == RM_RNE) ||
            (s1_rm == RM_RUP && !s1_sign) ||
            (s1_rm == 2'd3 && s1_sign)) begin
          res_d = {s1_sign, 8'hFF, 23'b0};
          inf_d = 1'b1;
        end else begin
          res_d = {s1_sign, 31'h7F7FFFFF};
        end
      end else if (exp_r <= 11'sd0) begin
        // Flush to zero; subnormals are never produced.
        res_d = {s1_sign, 31'b0};
        unf_d = 1'b1;
        inx_d = 1'b1;
      end else begin
        res_d = {s1_sign, exp_r[7:0], mant_r[22:0]};
        inx_d = s1_g | s1_s;
      end
    end else if (s1_cls == CLS_ZERO) begin
      res_d = {s1_sign, 31'b0};
    end else if (s1_cls == CLS_INF) begin
      res_d = {s1_sign, 8'hFF, 23'b0};
      inf_d = 1'b1;
    end else begin
      res_d = 32'h7FC00000;
      nan_d = 1'b1;
    end
  end

  // Stage 2 output registers; hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= 32'h0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
      out_inf       <= 1'b0;
      out_nan       <= 1'b0;
    end else if (advance) begin
      out_valid     <= s1_valid;
      out_result    <= res_d;
      out_overflow  <= ovf_d;
      out_underflow <= unf_d;
      out_inexact   <= inx_d;
      out_inf       <= inf_d;
      out_nan       <= nan_d;
    end
  end

endmodule
